// File: rtl/fc_param_streamer.sv
// Weight/bias source for the FC MAC stage: streams stored weight words in step with the activation beats.
// Optional FC_PARAM_TIMEOUT_EN: rewinds the weight index after 8 idle cycles.
module fc_param_streamer #(
    parameter int unsigned I_BW        = 8,
    parameter int unsigned BIAS_BW     = I_BW * 2,
    parameter int unsigned NUM_CLASSES = 3,
    parameter int unsigned VEC_LEN     = 208,
    parameter int unsigned ADDR_BW     = $clog2(VEC_LEN)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           cfg_w_wr_i,
    input  logic                           cfg_b_wr_i,
    input  logic [ADDR_BW-1:0]             cfg_addr_i,
    input  logic [NUM_CLASSES*I_BW-1:0]    cfg_data_i,
    input  logic [NUM_CLASSES*BIAS_BW-1:0] cfg_bias_i,
    input  logic                           cfg_done_i,
    output logic                           cfg_err_o,
    input  logic                           act_valid_i,
    input  logic                           act_last_i,
    output logic                           act_ready_o,
    output logic [NUM_CLASSES*I_BW-1:0]    data_w_o,
    output logic [NUM_CLASSES*BIAS_BW-1:0] data_b_o,
    output logic                           valid_o,
    output logic                           last_o,
    input  logic                           ready_i,
    output logic                           len_err_o
);
    localparam int unsigned W_W    = NUM_CLASSES * I_BW;
    localparam int unsigned B_W    = NUM_CLASSES * BIAS_BW;
    localparam int unsigned MEM_AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [ADDR_BW-1:0] IDX_LAST = ADDR_BW'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY       = 2'd0,
        LOADED_IDLE = 2'd1,
        STREAM      = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_BW-1:0] idx_q, idx_d;
    logic [B_W-1:0]     bias_q, bias_d;
    logic               cfg_err_q, cfg_err_d;
    logic               len_err_q, len_err_d;
    logic               w_ok;
    logic [W_W-1:0]     mem_q [VEC_LEN];

    logic loaded, beat, at_end;

`ifdef FC_PARAM_TIMEOUT_EN
    logic [3:0] idle_q, idle_d;
`endif

    // Handshake and read path are combinational so both MAC inputs stay beat-aligned.
    assign loaded      = (state_q != EMPTY);
    assign valid_o     = act_valid_i && loaded;
    assign act_ready_o = ready_i && loaded;
    assign at_end      = (idx_q == IDX_LAST);
    assign last_o      = valid_o && (at_end || act_last_i);
    assign beat        = valid_o && ready_i;
    assign data_w_o    = mem_q[MEM_AW'(idx_q)];
    assign data_b_o    = bias_q;
    assign cfg_err_o   = cfg_err_q;
    assign len_err_o   = len_err_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bias_d    = bias_q;
        cfg_err_d = cfg_err_q;
        len_err_d = len_err_q;
        w_ok      = 1'b0;
`ifdef FC_PARAM_TIMEOUT_EN
        idle_d    = idle_q;
`endif

        // Parameters may only change while no packet is in flight.
        if (cfg_w_wr_i) begin
            if (state_q != STREAM && 32'(cfg_addr_i) < VEC_LEN) begin
                w_ok = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
        if (cfg_b_wr_i) begin
            if (state_q != STREAM) begin
                bias_d = cfg_bias_i;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (beat) begin
            idx_d = last_o ? '0 : idx_q + ADDR_BW'(1);
            if (act_last_i && !at_end) begin
                len_err_d = 1'b1;
            end
        end

`ifdef FC_PARAM_TIMEOUT_EN
        // Mirrors the MAC's accumulator-clear timeout so a stalled packet restarts at word 0.
        if (act_valid_i) begin
            idle_d = 4'd0;
        end else if (idle_q != 4'd8) begin
            idle_d = idle_q + 4'd1;
        end
        if (idle_d == 4'd8) begin
            idx_d = '0;
        end
`endif

        case (state_q)
            EMPTY: begin
                if (cfg_done_i) begin
                    state_d = LOADED_IDLE;
                end
            end
            default: begin
                state_d = (idx_d != '0) ? STREAM : LOADED_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= EMPTY;
            idx_q     <= '0;
            bias_q    <= '0;
            cfg_err_q <= 1'b0;
            len_err_q <= 1'b0;
`ifdef FC_PARAM_TIMEOUT_EN
            idle_q    <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            bias_q    <= bias_d;
            cfg_err_q <= cfg_err_d;
            len_err_q <= len_err_d;
`ifdef FC_PARAM_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    // Weight store has no reset; contents survive a reset and are re-armed by cfg_done_i.
    always_ff @(posedge clk_i) begin
        if (w_ok) begin
            mem_q[MEM_AW'(cfg_addr_i)] <= cfg_data_i;
        end
    end

endmodule

// File: tb/tb_fc_param_streamer.sv
// Directed bench for fc_param_streamer at VEC_LEN=4 (ADDR_BW=3 so an out-of-range address is expressible).
module tb_fc_param_streamer;
    localparam int unsigned I_BW = 8;
    localparam int unsigned BIAS_BW = 16;
    localparam int unsigned NC = 3;
    localparam int unsigned VL = 4;
    localparam int unsigned AW = 3;

    logic              clk, rst_n;
    logic              cfg_w_wr, cfg_b_wr, cfg_done;
    logic [AW-1:0]     cfg_addr;
    logic [NC*I_BW-1:0]    cfg_data;
    logic [NC*BIAS_BW-1:0] cfg_bias;
    logic              cfg_err;
    logic              act_valid, act_last, act_ready;
    logic [NC*I_BW-1:0]    data_w;
    logic [NC*BIAS_BW-1:0] data_b;
    logic              valid_o, last_o, ready, len_err;

    int n_vec = 0;
    int n_err = 0;
    logic [23:0] w_tab [4];
    localparam logic [47:0] B0 = 48'h0001_0002_0003;
    localparam logic [47:0] B1 = 48'h0004_0005_0006;
    localparam logic [47:0] B2 = 48'h0007_0008_0009;

    fc_param_streamer #(
        .I_BW(I_BW), .BIAS_BW(BIAS_BW), .NUM_CLASSES(NC), .VEC_LEN(VL), .ADDR_BW(AW)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_w_wr_i(cfg_w_wr), .cfg_b_wr_i(cfg_b_wr), .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data), .cfg_bias_i(cfg_bias), .cfg_done_i(cfg_done),
        .cfg_err_o(cfg_err), .act_valid_i(act_valid), .act_last_i(act_last),
        .act_ready_o(act_ready), .data_w_o(data_w), .data_b_o(data_b),
        .valid_o(valid_o), .last_o(last_o), .ready_i(ready), .len_err_o(len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One accepted beat at the current index; checks the word and last flag.
    task automatic beat(input int i, input logic last_in, input logic exp_last);
        act_valid = 1'b1;
        act_last  = last_in;
        ready     = 1'b1;
        #1;
        chk1("beat_valid", valid_o, 1'b1);
        chkw("beat_w", 64'(data_w), 64'(w_tab[i]));
        chk1("beat_last", last_o, exp_last);
        tick();
        act_valid = 1'b0;
        act_last  = 1'b0;
    endtask

    initial begin
        w_tab[0] = 24'h010203;
        w_tab[1] = 24'h040506;
        w_tab[2] = 24'h070809;
        w_tab[3] = 24'h0A0B0C;
        cfg_w_wr = 0; cfg_b_wr = 0; cfg_done = 0; cfg_addr = '0;
        cfg_data = '0; cfg_bias = '0; act_valid = 0; act_last = 0; ready = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); #1;
        chk1("rst_ardy", act_ready, 1'b0);
        chk1("rst_valid", valid_o, 1'b0);
        chk1("rst_last", last_o, 1'b0);
        chkw("rst_bias", 64'(data_b), 64'(0));
        chk1("rst_cfg_err", cfg_err, 1'b0);
        chk1("rst_len_err", len_err, 1'b0);
        tick();
        rst_n = 1'b1;

        // Not yet loaded: activations are ignored.
        act_valid = 1; ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("unl_valid", valid_o, 1'b0);
            chk1("unl_ardy", act_ready, 1'b0);
            tick();
        end
        act_valid = 0;

        for (int a = 0; a < 4; a++) begin
            cfg_w_wr = 1; cfg_addr = AW'(a); cfg_data = w_tab[a];
            tick();
        end
        cfg_w_wr = 0;
        cfg_b_wr = 1; cfg_bias = B0;
        tick();
        cfg_b_wr = 0;
        #1;
        chkw("load_bias", 64'(data_b), 64'(B0));
        chk1("load_cfg_err", cfg_err, 1'b0);
        cfg_done = 1;
        tick();
        cfg_done = 0;
        #1;
        chk1("idle_ardy", act_ready, 1'b1);
        chk1("idle_valid", valid_o, 1'b0);
        ready = 0;
        #1;
        chk1("idle_ardy_lo", act_ready, 1'b0);

        // Packet 1: four back-to-back beats.
        beat(0, 0, 0); beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 1);
        #1;
        chk1("p1_len_err", len_err, 1'b0);

        // Packet 2: three stall cycles at idx 2.
        beat(0, 0, 0); beat(1, 0, 0);
        act_valid = 1; ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chkw("stall_w", 64'(data_w), 64'(w_tab[2]));
            chk1("stall_valid", valid_o, 1'b1);
            chk1("stall_ardy", act_ready, 1'b0);
            chk1("stall_last", last_o, 1'b0);
            tick();
        end
        beat(2, 0, 0); beat(3, 0, 1);

        // Packet 3: weight write while idx=2 is rejected.
        beat(0, 0, 0); beat(1, 0, 0);
        cfg_w_wr = 1; cfg_addr = 3'd1; cfg_data = 24'hFFFFFF;
        #1;
        chk1("mid_wr_err_pre", cfg_err, 1'b0);
        tick();
        cfg_w_wr = 0;
        #1;
        chk1("mid_wr_err", cfg_err, 1'b1);
        beat(2, 0, 0); beat(3, 0, 1);

        // Packet 4: mem[1] unchanged, early act_last on beat 2 resyncs.
        beat(0, 0, 0);
        beat(1, 1, 1);
        #1;
        chk1("early_len_err", len_err, 1'b1);
        beat(0, 0, 0); beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 1);

        // Idle gap of 8 cycles mid-packet.
        beat(0, 0, 0); beat(1, 0, 0);
        for (int k = 0; k < 8; k++) tick();
`ifdef FC_PARAM_TIMEOUT_EN
        beat(0, 0, 0); beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 1);
`else
        beat(2, 0, 0); beat(3, 0, 1);
`endif

        // Reset mid-packet: flags clear, memory retained, reload required.
        beat(0, 0, 0);
        rst_n = 0; act_valid = 1; ready = 1;
        #1;
        chk1("mrst_valid", valid_o, 1'b0);
        chk1("mrst_ardy", act_ready, 1'b0);
        chk1("mrst_cfg_err", cfg_err, 1'b0);
        chk1("mrst_len_err", len_err, 1'b0);
        chkw("mrst_bias", 64'(data_b), 64'(0));
        tick();
        rst_n = 1;
        #1;
        chk1("mrst_empty_valid", valid_o, 1'b0);
        act_valid = 0;
        cfg_b_wr = 1; cfg_bias = B0;
        cfg_done = 1;
        tick();
        cfg_b_wr = 0; cfg_done = 0;

        // Bias write alongside a beat at idx 0 is accepted.
        act_valid = 1; ready = 1; cfg_b_wr = 1; cfg_bias = B1;
        #1;
        chkw("bias_idle_w", 64'(data_w), 64'(w_tab[0]));
        chkw("bias_idle_old", 64'(data_b), 64'(B0));
        tick();
        cfg_b_wr = 0; act_valid = 0;
        #1;
        chkw("bias_idle_new", 64'(data_b), 64'(B1));
        chk1("bias_idle_err", cfg_err, 1'b0);

        // Bias write with a beat at idx 1 is dropped.
        act_valid = 1; cfg_b_wr = 1; cfg_bias = B2;
        #1;
        chkw("bias_strm_w", 64'(data_w), 64'(w_tab[1]));
        tick();
        cfg_b_wr = 0; act_valid = 0;
        #1;
        chkw("bias_strm_kept", 64'(data_b), 64'(B1));
        chk1("bias_strm_err", cfg_err, 1'b1);
        beat(2, 0, 0); beat(3, 0, 1);

        // Out-of-range address in idle must not alias onto mem[0].
        rst_n = 0;
        #1;
        chk1("rst2_cfg_err", cfg_err, 1'b0);
        tick();
        rst_n = 1;
        cfg_w_wr = 1; cfg_addr = 3'd4; cfg_data = 24'hDEAD00;
        tick();
        cfg_w_wr = 0;
        #1;
        chk1("oor_err", cfg_err, 1'b1);
        cfg_done = 1;
        tick();
        cfg_done = 0;
        beat(0, 0, 0); beat(1, 0, 0); beat(2, 0, 0); beat(3, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
